// File: rtl/clock_pkg.sv
// clock_pkg: shared calendar constants, field widths and the divider-free leap-year rule
package clock_pkg;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 12;
  localparam logic [DAY_W-1:0] DAY_MIN = 5'd1;
  localparam logic [DAY_W-1:0] DAY_MAX = 5'd31;
  localparam logic [MON_W-1:0] MON_JAN = 4'd1;
  localparam logic [MON_W-1:0] MON_FEB = 4'd2;
  localparam logic [MON_W-1:0] MON_MAR = 4'd3;
  localparam logic [MON_W-1:0] MON_APR = 4'd4;
  localparam logic [MON_W-1:0] MON_MAY = 4'd5;
  localparam logic [MON_W-1:0] MON_JUN = 4'd6;
  localparam logic [MON_W-1:0] MON_JUL = 4'd7;
  localparam logic [MON_W-1:0] MON_AUG = 4'd8;
  localparam logic [MON_W-1:0] MON_SEP = 4'd9;
  localparam logic [MON_W-1:0] MON_OCT = 4'd10;
  localparam logic [MON_W-1:0] MON_NOV = 4'd11;
  localparam logic [MON_W-1:0] MON_DEC = 4'd12;
  // Gregorian leap test: low two bits give mod 4, century years are matched against the
  // constant multiples of 100 that fit in the year field, and every fourth century stays leap.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic cent;
    logic quad;
    cent = 1'b0;
    quad = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (y == YEAR_W'(k * 100)) begin
        cent = 1'b1;
        quad = (k % 4 == 0);
      end
    end
    return (y[1:0] == 2'b00) && (!cent || quad);
  endfunction
endpackage

// File: rtl/count_adjust_day_if.sv
// count_adjust_day_if: hour carry, adjust controls and month/year feedback into the day stage, day/carry out
interface count_adjust_day_if;
  import clock_pkg::*;
  logic              carry_hour;
  logic              adj_en;
  logic              adj_up;
  logic              adj_down;
  logic [MON_W-1:0]  mon;
  logic [YEAR_W-1:0] year;
  logic              carry_day;
  logic [DAY_W-1:0]  day;
  modport master (output carry_hour, adj_en, adj_up, adj_down, mon, year, input carry_day, day);
  modport slave (input carry_hour, adj_en, adj_up, adj_down, mon, year, output carry_day, day);
endinterface

// File: rtl/count_adjust_day_days_in_month.sv
// days_in_month: month length from mon/year; February leap handling enabled by CENTURY_CLOCK_LEAP_YEAR_EN
module days_in_month
  import clock_pkg::*;
(
  input  logic [MON_W-1:0]  mon_i,
  input  logic [YEAR_W-1:0] year_i,
  output logic [DAY_W-1:0]  dim_o
);
  logic leap;
`ifdef CENTURY_CLOCK_LEAP_YEAR_EN
  assign leap = is_leap(year_i);
`else
  logic unused_year;
  assign unused_year = ^year_i;
  assign leap = 1'b0;
`endif
  // Month length lookup; out-of-range months fall back to the longest month
  always_comb begin
    case (mon_i)
      MON_FEB: dim_o = leap ? 5'd29 : 5'd28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: dim_o = 5'd30;
      default: dim_o = DAY_MAX;
    endcase
  end
endmodule

// File: rtl/count_adjust_day.sv
// count_adjust_day: day-of-month counter with manual adjust and month-end carry (leap rule via CENTURY_CLOCK_LEAP_YEAR_EN)
module count_adjust_day
  import clock_pkg::*;
(
  input logic clk,
  input logic rst_n,
  count_adjust_day_if.slave bus
);
  logic [DAY_W-1:0] dim;
  logic [DAY_W-1:0] day_q;
  logic             carry_q;
  days_in_month u_dim (
    .mon_i (bus.mon),
    .year_i(bus.year),
    .dim_o (dim)
  );
  // Repair illegal day, then adjust, then count on hour carry, else clamp to a shortened month
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q   <= DAY_MIN;
      carry_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (day_q == '0) day_q <= DAY_MIN;
      else if (bus.adj_en) begin
        if (bus.adj_up && !bus.adj_down) day_q <= (day_q >= dim) ? DAY_MIN : day_q + 5'd1;
        else if (bus.adj_down && !bus.adj_up) day_q <= (day_q == DAY_MIN || day_q > dim) ? dim : day_q - 5'd1;
      end else if (bus.carry_hour) begin
        if (day_q >= dim) begin
          day_q   <= DAY_MIN;
          carry_q <= 1'b1;
        end else day_q <= day_q + 5'd1;
      end else if (day_q > dim) day_q <= dim;
    end
  end
  assign bus.day       = day_q;
  assign bus.carry_day = carry_q;
endmodule

// File: doc/count_adjust_day.md
# count_adjust_day

Day-of-month counter with manual adjust. Sits directly upstream of the month counter: advances on the hour-stage carry, wraps at the month length and emits a one-cycle `carry_day` pulse consumed by the month stage. Month length comes from the current `mon` and `year` values fed back from the month and year stages. Manual up/down adjust never generates a carry.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `carry_hour` in 1: single-cycle pulse from the hour stage at 23→0 rollover.
- `adj_en` in 1: adjust mode; while high, `carry_hour` is ignored.
- `adj_up` in 1: single-cycle increment request, valid only with `adj_en`.
- `adj_down` in 1: single-cycle decrement request, valid only with `adj_en`.
- `mon` in 4: current month, 1..12, from the month stage.
- `year` in 12: current full year, 0..4095, from the year stage.
- `carry_day` out 1: registered single-cycle pulse on month-end rollover.
- `day` out 5: current day of month, 1..31.

## Operation
- Reset values: `day`=1, `carry_day`=0.
- `carry_day` defaults to 0 every cycle and is high for exactly one cycle per rollover.
- `dim` is days-in-month from `mon`/`year`:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 28 for month 2, or 29 in a leap year (see Configuration).
  - Invalid `mon` (0, 13–15) gives `dim`=31.
- Per-cycle priority, first match wins:
  1. `day`==0 or `day`>31 → `day`=1.
  2. `adj_en` high:
     - `adj_up` only: `day`=`day`≥`dim` ? 1 : `day`+1.
     - `adj_down` only: `day`==1 ? `dim` : (`day`>`dim` ? `dim` : `day`−1).
     - Both or neither: hold.
     - No carry in any adjust case.
  3. `carry_hour` high:
     - `day`≥`dim` → `day`=1 and `carry_day`=1. This covers a stale `day`>`dim`, so no event is lost.
     - Otherwise `day`+1.
  4. `day`>`dim` (month or year changed under the counter, e.g. 31 Jan → Feb) → clamp `day`=`dim`, no carry.
  5. Else hold.
- All arithmetic is 5-bit unsigned. Comparisons against `dim` use a 5-bit `dim`.

## Timing
- One-cycle latency: inputs sampled at edge N take effect in `day`/`carry_day` after edge N.
- `carry_day` rises the cycle after the `carry_hour` that caused the rollover. The month stage updates one cycle later still.
- During that gap the day stage sees the old `mon`. This is harmless because `day` is already 1.
- Clamp after an external `mon` change occurs one cycle after `mon` changes.
- `adj_en` falling with `carry_hour` high in the same cycle: counting resumes. `adj_en` is sampled in the same cycle as `carry_hour`.
- Reset asserted mid-operation: `day`=1 and `carry_day`=0 immediately (asynchronous). Any pending rollover is dropped.
- Back-to-back `carry_hour` pulses are each counted; there is no internal busy state.

## Configuration
- Macro `CENTURY_CLOCK_LEAP_YEAR_EN`.
- Defined: February has 29 days when `year`%4==0 and (`year`%100!=0 or `year`%400==0). The rule must be implemented without dividers, as a mod-4 bit test plus a constant compare against multiples of 100.
- Undefined: February is always 28 days. `year` is unused; the port remains for interface stability.

## Structure
- Shared package `clock_pkg` holds:
  - month constants `MON_JAN`..`MON_DEC`;
  - `DAY_MIN`=1 and `DAY_MAX`=31;
  - the width localparams for `day` (5), `mon` (4) and `year` (12).
- Sub-module `days_in_month` computes `dim` combinationally from `mon`/`year`, including the leap rule and the macro guard.
- The counter itself is a single always block in `count_adjust_day`.

## Test plan
- Reset, then 31 `carry_hour` pulses with `mon`=1 → `day` steps 1..31, then 1, with `carry_day` high exactly one cycle, the cycle after the 31st pulse.
- `mon`=2 with macro defined: `year`=2024 rolls after 29; `year`=2100 rolls after 28; `year`=2000 rolls after 29. Macro undefined, `year`=2024 → rolls after 28.
- `day`=31, `mon` switched 1→4 with no `carry_hour` → `day`=30 one cycle later, `carry_day` stays 0.
- `adj_en`=1, `mon`=4, `day`=30: `adj_up` → 1, then `adj_down` → 30; both together → hold. `carry_hour` pulses during adjust leave `day` unchanged and `carry_day` 0.
- `day`=31 and `mon` changed to 2 in the same cycle as `carry_hour` → `day`=1, `carry_day`=1.
- Assert `rst_n` low while `carry_day` is high → `day`=1 and `carry_day`=0 without waiting for a clock edge.
